rdmap_hdr_parse: RTL and testbench

Receive-side RDMAP header parser sitting between DDP and the RDMA operation logic. It takes DDP-delivered 56-bit RDMAP headers with their 8-bit control, decodes them by opcode back into control and work-request fields, and buffers the results in a small FIFO. Downstream drains the FIFO through a valid/ready handshake. For ACK headers it also replays the four carried queue numbers, one per cycle, to the register pool.

---
 rtl/rdmap_hdr_parse_if.sv | 25 ++
 rtl/rdmap_hdr_parse.sv | 153 +++++++++++++++
 tb/tb_rdmap_hdr_parse.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/rdmap_hdr_parse_if.sv
// Bundle of DDP-facing inputs and RDMA-operation-facing outputs of the RDMAP header parser.
// The parser uses the slave modport; whatever drives headers and drains records uses master.
interface rdmap_hdr_parse_if;
  logic [55:0] ddp2RdmapHeader;
  logic [7:0]  ddp2RdmapCtrl;
  logic        ddp2RdmapHdrValid;
  logic        infoValid;
  logic [15:0] rdmaControl;
  logic [51:0] rdmaWR;
  logic        infoReady;
  logic        qnRelease;
  logic [3:0]  qnNum;
  logic        hdrError;
  logic        overflow;

  modport master (
    output ddp2RdmapHeader, ddp2RdmapCtrl, ddp2RdmapHdrValid, infoReady,
    input  infoValid, rdmaControl, rdmaWR, qnRelease, qnNum, hdrError, overflow
  );

  modport slave (
    input  ddp2RdmapHeader, ddp2RdmapCtrl, ddp2RdmapHdrValid, infoReady,
    output infoValid, rdmaControl, rdmaWR, qnRelease, qnNum, hdrError, overflow
  );
endinterface

// File: rtl/rdmap_hdr_parse.sv
// Receive-side RDMAP header parser: register, decode by opcode, buffer decoded records
// in a small FIFO, and replay the four queue numbers of each popped ACK.
module rdmap_hdr_parse #(
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [7:0] SEND_OPCODE = 8'h00,
  parameter logic [7:0] RCV_OPCODE  = 8'h01,
  parameter logic [7:0] REQ_OPCODE  = 8'h03,
  parameter logic [7:0] ACK_OPCODE  = 8'h07
) (
  input logic             clock,
  input logic             reset,
  rdmap_hdr_parse_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [51:0] wr;
    logic [15:0] qn;
    logic        is_ack;
  } rec_t;

  typedef enum logic [2:0] {S_IDLE, S_Q0, S_Q1, S_Q2, S_Q3} qn_state_t;

  logic [55:0]   hdr_reg;
  logic [7:0]    ctrl_reg;
  logic          vld_reg;
  rec_t          dec_rec;
  logic          dec_ok;
  rec_t          mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          hdr_error_reg, overflow_reg;
  qn_state_t     state_reg;
  logic [15:0]   qn_latch_reg;
  logic          qn_release_reg;
  logic [3:0]    qn_num_reg;
  rec_t          head;
  logic          empty, full, seq_busy, info_valid, pop, push, ack_pop;

  always_comb begin
    dec_ok      = 1'b0;
    dec_rec     = '0;
    dec_rec.ctrl = ctrl_reg;
    if (ctrl_reg == ACK_OPCODE) begin
      dec_ok         = (hdr_reg[23:0] == 24'd0);
      dec_rec.wr     = {hdr_reg[55:40], 36'd0};
      dec_rec.qn     = hdr_reg[39:24];
      dec_rec.is_ack = 1'b1;
    end else if (ctrl_reg == SEND_OPCODE) begin
      dec_ok     = (hdr_reg[47:0] == 48'd0);
      dec_rec.wr = {8'd0, hdr_reg[55:48], 36'd0};
    end else if (ctrl_reg == REQ_OPCODE || ctrl_reg == RCV_OPCODE) begin
      dec_ok     = (hdr_reg[3:0] == 4'd0);
      dec_rec.wr = hdr_reg[55:4];
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(FIFO_DEPTH));
  // Q3 carries the final release, so the next ACK may pop then and continue without a gap.
  assign seq_busy   = (state_reg == S_Q0) || (state_reg == S_Q1) || (state_reg == S_Q2);
  assign info_valid = !empty && !(head.is_ack && seq_busy);
  assign pop        = info_valid && bus.infoReady;
  assign ack_pop    = pop && head.is_ack;
  assign push       = vld_reg && dec_ok && (!full || pop);

  assign bus.infoValid   = info_valid;
  assign bus.rdmaControl = empty ? 16'd0 : {8'd0, head.ctrl};
  assign bus.rdmaWR      = empty ? 52'd0 : head.wr;
  assign bus.hdrError    = hdr_error_reg;
  assign bus.overflow    = overflow_reg;
  assign bus.qnRelease   = qn_release_reg;
  assign bus.qnNum       = qn_num_reg;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_reg] <= dec_rec;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hdr_reg       <= '0;
      ctrl_reg      <= '0;
      vld_reg       <= 1'b0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      hdr_error_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      hdr_reg       <= bus.ddp2RdmapHeader;
      ctrl_reg      <= bus.ddp2RdmapCtrl;
      vld_reg       <= bus.ddp2RdmapHdrValid;
      hdr_error_reg <= vld_reg && !dec_ok;
      if (vld_reg && dec_ok && full && !pop) overflow_reg <= 1'b1;
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      qn_latch_reg   <= '0;
      qn_release_reg <= 1'b0;
      qn_num_reg     <= '0;
    end else begin
      qn_release_reg <= 1'b0;
      qn_num_reg     <= '0;
      case (state_reg)
        S_IDLE: begin
          if (ack_pop) begin
            state_reg    <= S_Q0;
            qn_latch_reg <= head.qn;
          end
        end
        S_Q0: begin
          qn_release_reg <= 1'b1;
          qn_num_reg     <= qn_latch_reg[15:12];
          state_reg      <= S_Q1;
        end
        S_Q1: begin
          qn_release_reg <= 1'b1;
          qn_num_reg     <= qn_latch_reg[11:8];
          state_reg      <= S_Q2;
        end
        S_Q2: begin
          qn_release_reg <= 1'b1;
          qn_num_reg     <= qn_latch_reg[7:4];
          state_reg      <= S_Q3;
        end
        S_Q3: begin
          qn_release_reg <= 1'b1;
          qn_num_reg     <= qn_latch_reg[3:0];
          if (ack_pop) begin
            state_reg    <= S_Q0;
            qn_latch_reg <= head.qn;
          end else begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rdmap_hdr_parse.sv
// Bench for rdmap_hdr_parse: directed scenarios then random traffic, all checked every cycle
// against a queue-based transaction model of decode, FIFO drop rules and QN replay.
module tb_rdmap_hdr_parse;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  rdmap_hdr_parse_if bus();

  rdmap_hdr_parse #(
    .FIFO_DEPTH(DEPTH), .SEND_OPCODE(8'h00), .RCV_OPCODE(8'h01),
    .REQ_OPCODE(8'h03), .ACK_OPCODE(8'h07)
  ) dut (
    .clock(clock),
    .reset(rst),
    .bus(bus)
  );

  typedef struct {
    logic [7:0]  ctrl;
    logic [51:0] wr;
    logic [15:0] qn;
    bit          ack;
  } rec_t;

  rec_t       q[$];
  logic [3:0] qn_pend[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic        prev_v = 1'b0;
  logic [55:0] prev_h = '0;
  logic [7:0]  prev_c = '0;
  logic        exp_valid = 1'b0, exp_rel = 1'b0, exp_err = 1'b0, exp_ovf = 1'b0;
  logic [3:0]  exp_num = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Decoding rules: each opcode has its own work-request layout and a pad field that must be zero.
  function automatic bit decode(input logic [55:0] h, input logic [7:0] c, output rec_t r);
    r.ctrl = c; r.wr = '0; r.qn = '0; r.ack = 1'b0;
    if (c == 8'h07) begin
      r.ack = 1'b1; r.wr = {h[55:40], 36'd0}; r.qn = h[39:24];
      return h[23:0] == 24'd0;
    end
    if (c == 8'h00) begin
      r.wr = {8'd0, h[55:48], 36'd0};
      return h[47:0] == 48'd0;
    end
    if (c == 8'h01 || c == 8'h03) begin
      r.wr = h[55:4];
      return h[3:0] == 4'd0;
    end
    return 1'b0;
  endfunction

  task automatic step(input logic [55:0] h, input logic [7:0] c, input logic v,
                      input logic r, input logic rs);
    bit   pop, ok;
    rec_t f, d;
    bus.ddp2RdmapHeader   = h;
    bus.ddp2RdmapCtrl     = c;
    bus.ddp2RdmapHdrValid = v;
    bus.infoReady         = r;
    rst                   = rs;
    pop = exp_valid && r;
    @(posedge clock);
    if (rs) begin
      q.delete(); qn_pend.delete();
      prev_v = 1'b0; exp_valid = 1'b0; exp_rel = 1'b0; exp_num = '0;
      exp_err = 1'b0; exp_ovf = 1'b0;
    end else begin
      exp_rel = 1'b0; exp_num = '0;
      if (qn_pend.size() > 0) begin
        exp_rel = 1'b1;
        exp_num = qn_pend.pop_front();
      end
      if (pop) begin
        f = q.pop_front();
        if (f.ack) for (int i = 3; i >= 0; i--) qn_pend.push_back(f.qn[i*4 +: 4]);
      end
      exp_err = 1'b0;
      if (prev_v) begin
        ok = decode(prev_h, prev_c, d);
        if (!ok) exp_err = 1'b1;
        else if (q.size() < DEPTH) q.push_back(d);
        else exp_ovf = 1'b1;
      end
      prev_v = v; prev_h = h; prev_c = c;
      // An ACK may leave only when at most one release of the previous ACK is still to come.
      exp_valid = (q.size() > 0) && !(q[0].ack && qn_pend.size() > 1);
    end
    #1;
    chk("infoValid", 64'(bus.infoValid), 64'(exp_valid));
    chk("qnRelease", 64'(bus.qnRelease), 64'(exp_rel));
    chk("hdrError",  64'(bus.hdrError),  64'(exp_err));
    chk("overflow",  64'(bus.overflow),  64'(exp_ovf));
    if (exp_rel) chk("qnNum", 64'(bus.qnNum), 64'(exp_num));
    if (exp_valid) begin
      chk("rdmaControl", 64'(bus.rdmaControl), 64'({8'd0, q[0].ctrl}));
      chk("rdmaWR",      64'(bus.rdmaWR),      64'(q[0].wr));
    end
    if (rs) begin
      chk("rst_qnNum",       64'(bus.qnNum),       64'd0);
      chk("rst_rdmaControl", 64'(bus.rdmaControl), 64'd0);
      chk("rst_rdmaWR",      64'(bus.rdmaWR),      64'd0);
    end
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step('0, 8'h00, 1'b0, r, 1'b0);
  endtask

  initial begin
    logic [63:0] r64;
    logic [55:0] h;
    logic [7:0]  c;
    int          k;

    bus.ddp2RdmapHeader = '0; bus.ddp2RdmapCtrl = '0;
    bus.ddp2RdmapHdrValid = 1'b0; bus.infoReady = 1'b0;
    step('0, 8'h00, 1'b0, 1'b0, 1'b1);
    step('0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Single REQ, then single ACK with QNs 5,6,7,8.
    step({52'hA_BCDE_F012_3456, 4'h0}, 8'h03, 1'b1, 1'b1, 1'b0);
    idle(4, 1'b1);
    step({16'h1234, 4'h5, 4'h6, 4'h7, 4'h8, 24'd0}, 8'h07, 1'b1, 1'b1, 1'b0);
    idle(8, 1'b1);

    // Good SEND, SEND with nonzero pad, unknown opcode.
    step({8'h5A, 48'd0}, 8'h00, 1'b1, 1'b1, 1'b0);
    step({8'h5A, 47'd0, 1'b1}, 8'h00, 1'b1, 1'b1, 1'b0);
    step({52'h1_2345_6789_ABCD, 4'h0}, 8'h0F, 1'b1, 1'b1, 1'b0);
    idle(4, 1'b1);

    // Six REQs against a stalled consumer, then drain.
    for (int i = 0; i < 6; i++)
      step({48'h0000_1000_0000 + 48'(i), 4'h0, 4'h0}, 8'h03, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("overflow_sticky", 64'(bus.overflow), 64'd1);
    idle(6, 1'b1);

    // Two back-to-back ACKs followed by a REQ.
    step({16'hAAAA, 16'h1234, 24'd0}, 8'h07, 1'b1, 1'b1, 1'b0);
    step({16'hBBBB, 16'h9ABC, 24'd0}, 8'h07, 1'b1, 1'b1, 1'b0);
    step({52'h0_0000_0000_0777, 4'h0}, 8'h03, 1'b1, 1'b1, 1'b0);
    idle(12, 1'b1);

    // Reset during the second QN release with two records waiting.
    step({16'hCCCC, 16'hFEDC, 24'd0}, 8'h07, 1'b1, 1'b1, 1'b0);
    step({52'h0_0000_0000_0101, 4'h0}, 8'h03, 1'b1, 1'b1, 1'b0);
    step({52'h0_0000_0000_0202, 4'h0}, 8'h01, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b0);
    chk("pre_rst_release", 64'(bus.qnRelease), 64'd1);
    step('0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("post_rst_overflow", 64'(bus.overflow), 64'd0);
    step({52'h0_0000_0000_0303, 4'h0}, 8'h03, 1'b1, 1'b1, 1'b0);
    idle(6, 1'b1);

    // Random traffic: first mostly-ready consumer, then a mostly-stalled one.
    for (int n = 0; n < 600; n++) begin
      r64 = {$urandom(), $urandom()};
      h   = r64[55:0];
      k   = $urandom_range(0, 9);
      c   = (k < 3) ? 8'h03 : (k < 5) ? 8'h01 : (k < 7) ? 8'h07 : (k < 9) ? 8'h00 : 8'($urandom());
      if ($urandom_range(0, 3) != 0) begin
        if (c == 8'h07)      h[23:0] = '0;
        else if (c == 8'h00) h[47:0] = '0;
        else                 h[3:0]  = '0;
      end
      step(h, c, 1'($urandom_range(0, 2) != 0),
           (n < 300) ? 1'($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 149) == 0));
    end
    idle(20, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
